lz77_ctl: RTL and testbench
===========================

# lz77_ctl

Frame-level scanline scheduler for `lz77_top` in the PNG encoder. It accepts one frame start, issues one `start` pulse to `lz77_top` per scanline, and never issues a pulse until the filter stage has committed a complete scanline to the filter FIFO (line-credit counter). It flags the last scanline for BFINAL handling, returns frame done, and records worst-case per-line LZ77 cycles.

## Interface
Parameters:
- `CRD_DEP`, 2: filter FIFO capacity in whole scanlines; the credit ceiling.
- `CRD_WD`, 2: credit counter width; must satisfy `2^CRD_WD > CRD_DEP`.
- `CYC_WD`, 16: cycle-count width.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `cfg_w_i` in `SIZE_W_WD`: frame width in pixels, latched at frame start.
- `cfg_h_i` in `SIZE_H_WD`: frame height in scanlines, latched at frame start.
- `start_i` in 1: frame start pulse; ignored while busy.
- `done_o` out 1: one-cycle frame-done pulse.
- `busy_o` out 1: high whenever the state is not IDLE.
- `flt_line_i` in 1: one-cycle pulse meaning one complete scanline was pushed to the filter FIFO.
- `lz_start_o` out 1: one-cycle start pulse to `lz77_top`.
- `lz_done_i` in 1: scanline done from `lz77_top`.
- `lz_w_o` out `SIZE_W_WD`: latched width, driven to `lz77_top.cfg_w_i`.
- `lz_lst_o` out 1: high from KICK through RUN of the final scanline.
- `cnt_h_o` out `SIZE_H_WD`: index of the current scanline.
- `crd_o` out `CRD_WD`: scanlines available in the FIFO.
- `crd_ovf_o` out 1: sticky credit-overflow error.
- `cyc_max_o` out `CYC_WD`: maximum per-line cycle count for the frame; saturating.

## Operation
- The state machine has five states: IDLE, WAIT, KICK, RUN, FIN.
- IDLE:
  - On `start_i`, latch `cfg_w_i` and `cfg_h_i`, clear `cnt_h`, `cyc_max` and `crd_ovf`.
  - If `cfg_w_i==0` or `cfg_h_i==0`, go to FIN. Otherwise go to WAIT.
- WAIT: if the registered `crd>0`, go to KICK. Otherwise stay in WAIT.
- KICK: `lz_start_o=1` for exactly this cycle. Decrement the credit. Clear the line cycle counter. Go to RUN.
- RUN:
  - The line cycle counter increments every cycle and saturates at all-ones.
  - On `lz_done_i`, update `cyc_max` with max(`cyc_max`, counter+1).
  - Then, if `cnt_h==h_lat-1`, go to FIN. Otherwise increment `cnt_h` and go to WAIT.
- FIN: `done_o=1` for exactly this cycle. Go to IDLE.
- Credit counter:
  - `flt_line_i` increments the count. A KICK decrements it.
  - When both occur in the same cycle, the net change is zero.
  - When the count is at `CRD_DEP`, a `flt_line_i` without a simultaneous KICK holds the count and sets `crd_ovf_o`.
  - Credit persists across frames and IDLE. Only `rst` clears it.
- `lz_done_i` is ignored outside RUN. `start_i` is ignored outside IDLE.
- `lz_lst_o = (cnt_h==h_lat-1)` qualified by state being KICK or RUN.
- Widths:
  - `cnt_h` compares against `h_lat-1` computed at `SIZE_H_WD` bits. This is safe because `h_lat>=1` whenever that comparison is reached.
  - `cyc_max` compares at `CYC_WD` bits.

## Timing
- Reset values:
  - State is IDLE.
  - `done_o`, `busy_o`, `lz_start_o`, `lz_lst_o`, `crd_ovf_o` are 0.
  - `lz_w_o`, `cnt_h_o`, `crd_o`, `cyc_max_o` are 0.
- Reset asserted mid-frame returns the block to IDLE immediately and drops the credit. `lz77_top` must be reset on the same `rst`.
- All outputs are registered or are pure decodes of registered state. There are no input-to-output combinational paths.
- Start to first pulse: `start_i` sampled at edge 0 gives WAIT in cycle 1 and KICK/`lz_start_o` in cycle 2, provided credit was nonzero at edge 1.
- Credit arrival: a `flt_line_i` sampled at edge k is visible in `crd` after edge k. KICK occurs no earlier than cycle k+2.
- Line to line: `lz_done_i` sampled at edge d gives WAIT in cycle d+1 and the next `lz_start_o` in cycle d+2, provided credit is available.
- Last line: `lz_done_i` at edge d gives FIN; `done_o` is high in cycle d+1 and `busy_o` falls in cycle d+2.
- Zero-size frame: `done_o` is high in the cycle after `start_i` and no `lz_start_o` is issued.
- Line cycle count equals the number of RUN cycles up to and including the `lz_done_i` cycle.

## Structure
- The shared define header holds `SIZE_W_WD`, `SIZE_H_WD` and the state encodings `LZ_CTL_IDLE..LZ_CTL_FIN` (3-bit).
- The credit counter is a natural sub-module, `lz77_ctl_crd`, with ports inc, dec, count, ovf and clear-ovf.
- The FSM, row counter and cycle statistics stay in `lz77_ctl`.
- Top-level wiring:
  - `lz_start_o` drives `lz77_top.start_i`.
  - `lz_done_i` is driven by `lz77_top.done_o`.
  - `lz_lst_o` qualifies `flg_lst_o` for BFINAL.

## Test plan
- **Basic frame:** w=256, h=4; credit preloaded to 2, then one `flt_line_i` per `lz_done_i` -> exactly 4 `lz_start_o` pulses, each 2 cycles after the `lz_done_i` (first one 2 after `start_i`). `lz_lst_o` is high only on line 3. One `done_o`, one cycle after the 4th `lz_done_i`.
- **Credit starvation:** credit 0; `start_i`, then `flt_line_i` 20 cycles later -> WAIT holds with no `lz_start_o` until 2 cycles after `flt_line_i`.
- **Simultaneous inc/dec and overflow:** `flt_line_i` in the KICK cycle with `crd=2` -> `crd` stays 2 and `crd_ovf_o` stays 0. A further `flt_line_i` with `crd=2` and no KICK -> `crd_ovf_o=1` and `crd=2`; the next `start_i` clears `crd_ovf_o`.
- **Zero size:** h=0 -> `done_o` one cycle after `start_i`, no `lz_start_o`. Same result for w=0, h=5.
- **Stray inputs:** `start_i` during RUN and `lz_done_i` during WAIT -> no state change, `cnt_h_o` unchanged.
- **Mid-frame reset:** assert `rst` during line 2 RUN -> all outputs 0 and IDLE asynchronously. A new frame with h=1 then completes normally with `cyc_max_o` equal to that line's RUN length, e.g. 300.

Source files
------------

// File: rtl/lz77_ctl_pkg.sv
// Shared widths and FSM state encodings for the lz77 scanline scheduler.
package lz77_ctl_pkg;

    localparam int SIZE_W_WD = 16;
    localparam int SIZE_H_WD = 16;

    localparam logic [2:0] LZ_CTL_IDLE = 3'd0;
    localparam logic [2:0] LZ_CTL_WAIT = 3'd1;
    localparam logic [2:0] LZ_CTL_KICK = 3'd2;
    localparam logic [2:0] LZ_CTL_RUN  = 3'd3;
    localparam logic [2:0] LZ_CTL_FIN  = 3'd4;

endpackage

// File: rtl/lz77_ctl_crd.sv
// Scanline credit counter: one credit per line committed to the filter FIFO.
// Registered count, one-cycle update; inc at the ceiling holds and raises sticky ovf.
module lz77_ctl_crd
    import lz77_ctl_pkg::*;
#(
    parameter int CRD_DEP = 2,
    parameter int CRD_WD  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              dec,
    input  logic              clr_ovf,
    output logic [CRD_WD-1:0] count,
    output logic              ovf
);

    localparam logic [CRD_WD-1:0] CRD_MAX = CRD_WD'(CRD_DEP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            if (clr_ovf) begin
                ovf <= 1'b0;
            end
            // A simultaneous inc and dec nets to zero and can never overflow.
            if (inc && !dec) begin
                if (count == CRD_MAX) begin
                    ovf <= 1'b1;
                end else begin
                    count <= count + 1'b1;
                end
            end else if (dec && !inc) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/lz77_ctl.sv
// Frame scheduler: one lz77 start pulse per scanline, gated by line credits.
// Start->kick 2 cycles, done->next kick 2 cycles; waits in WAIT while credit is zero.
module lz77_ctl
    import lz77_ctl_pkg::*;
#(
    parameter int CRD_DEP = 2,
    parameter int CRD_WD  = 2,
    parameter int CYC_WD  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [SIZE_W_WD-1:0] cfg_w_i,
    input  logic [SIZE_H_WD-1:0] cfg_h_i,
    input  logic                 start_i,
    output logic                 done_o,
    output logic                 busy_o,
    input  logic                 flt_line_i,
    output logic                 lz_start_o,
    input  logic                 lz_done_i,
    output logic [SIZE_W_WD-1:0] lz_w_o,
    output logic                 lz_lst_o,
    output logic [SIZE_H_WD-1:0] cnt_h_o,
    output logic [CRD_WD-1:0]    crd_o,
    output logic                 crd_ovf_o,
    output logic [CYC_WD-1:0]    cyc_max_o
);

    logic [2:0]           state;
    logic [SIZE_H_WD-1:0] h_lat;
    logic [SIZE_H_WD-1:0] cnt_h;
    logic [CYC_WD-1:0]    cyc;
    logic [CYC_WD-1:0]    cyc_inc;
    logic                 kick;
    logic                 last_line;

    assign kick      = (state == LZ_CTL_KICK);
    assign last_line = (cnt_h == (h_lat - 1'b1));
    assign cyc_inc   = (&cyc) ? cyc : cyc + 1'b1;

    lz77_ctl_crd #(
        .CRD_DEP (CRD_DEP),
        .CRD_WD  (CRD_WD)
    ) u_crd (
        .clk     (clk),
        .rst     (rst),
        .inc     (flt_line_i),
        .dec     (kick),
        .clr_ovf ((state == LZ_CTL_IDLE) && start_i),
        .count   (crd_o),
        .ovf     (crd_ovf_o)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= LZ_CTL_IDLE;
            lz_w_o    <= '0;
            h_lat     <= '0;
            cnt_h     <= '0;
            cyc       <= '0;
            cyc_max_o <= '0;
        end else begin
            case (state)
                LZ_CTL_IDLE: begin
                    if (start_i) begin
                        lz_w_o    <= cfg_w_i;
                        h_lat     <= cfg_h_i;
                        cnt_h     <= '0;
                        cyc_max_o <= '0;
                        state     <= (cfg_w_i == '0 || cfg_h_i == '0) ? LZ_CTL_FIN : LZ_CTL_WAIT;
                    end
                end
                LZ_CTL_WAIT: begin
                    if (crd_o != '0) begin
                        state <= LZ_CTL_KICK;
                    end
                end
                LZ_CTL_KICK: begin
                    cyc   <= '0;
                    state <= LZ_CTL_RUN;
                end
                LZ_CTL_RUN: begin
                    cyc <= cyc_inc;
                    // cyc_inc counts the done cycle itself as part of the line.
                    if (lz_done_i) begin
                        if (cyc_inc > cyc_max_o) begin
                            cyc_max_o <= cyc_inc;
                        end
                        if (last_line) begin
                            state <= LZ_CTL_FIN;
                        end else begin
                            cnt_h <= cnt_h + 1'b1;
                            state <= LZ_CTL_WAIT;
                        end
                    end
                end
                LZ_CTL_FIN: state <= LZ_CTL_IDLE;
                default:    state <= LZ_CTL_IDLE;
            endcase
        end
    end

    assign lz_start_o = kick;
    assign done_o     = (state == LZ_CTL_FIN);
    assign busy_o     = (state != LZ_CTL_IDLE);
    assign lz_lst_o   = (kick || state == LZ_CTL_RUN) && last_line;
    assign cnt_h_o    = cnt_h;

endmodule

// File: tb/tb_lz77_ctl.sv
// Scoreboard bench for lz77_ctl: stimulus queues expected start/done pulses, a monitor checks them.
module tb_lz77_ctl;
    import lz77_ctl_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [SIZE_W_WD-1:0] cfg_w_i;
    logic [SIZE_H_WD-1:0] cfg_h_i;
    logic                 start_i, flt_line_i, lz_done_i;
    logic                 done_o, busy_o, lz_start_o, lz_lst_o, crd_ovf_o;
    logic [SIZE_W_WD-1:0] lz_w_o;
    logic [SIZE_H_WD-1:0] cnt_h_o;
    logic [1:0]           crd_o;
    logic [15:0]          cyc_max_o;

    typedef struct {
        bit is_done;
        int cyc;
        bit lst;
        int row;
        int w;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;

    lz77_ctl #(.CRD_DEP(2), .CRD_WD(2), .CYC_WD(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_w_i    (cfg_w_i),
        .cfg_h_i    (cfg_h_i),
        .start_i    (start_i),
        .done_o     (done_o),
        .busy_o     (busy_o),
        .flt_line_i (flt_line_i),
        .lz_start_o (lz_start_o),
        .lz_done_i  (lz_done_i),
        .lz_w_o     (lz_w_o),
        .lz_lst_o   (lz_lst_o),
        .cnt_h_o    (cnt_h_o),
        .crd_o      (crd_o),
        .crd_ovf_o  (crd_ovf_o),
        .cyc_max_o  (cyc_max_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void push_ev(input bit d, input int c, input bit l, input int r, input int w);
        ev_t e;
        e.is_done = d;
        e.cyc     = c;
        e.lst     = l;
        e.row     = r;
        e.w       = w;
        exp_q.push_back(e);
    endfunction

    // Monitor: every start or done pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        ev_t e;
        if (!rst && (lz_start_o || done_o)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: start=%0b done=%0b at cycle %0d, expected no pulse",
                         lz_start_o, done_o, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("pulse_is_done", 64'(done_o), 64'(e.is_done));
                chk("pulse_cycle", 64'(cyc), 64'(e.cyc));
                if (!e.is_done) begin
                    chk("kick_lst", 64'(lz_lst_o), 64'(e.lst));
                    chk("kick_row", 64'(cnt_h_o), 64'(e.row));
                    chk("kick_w", 64'(lz_w_o), 64'(e.w));
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_flt();
        flt_line_i = 1'b1;
        tick();
        flt_line_i = 1'b0;
    endtask

    task automatic start_frame(input int w, input int h, input bit push_kick);
        cfg_w_i = SIZE_W_WD'(w);
        cfg_h_i = SIZE_H_WD'(h);
        start_i = 1'b1;
        if (w == 0 || h == 0) push_ev(1'b1, cyc + 1, 1'b0, 0, 0);
        else if (push_kick)   push_ev(1'b0, cyc + 2, h == 1, 0, w);
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_kick();
        int n;
        n = 0;
        while (!lz_start_o && n < 500) begin
            tick();
            n++;
        end
        if (!lz_start_o) begin
            checks++;
            errors++;
            $display("FAIL kick_timeout: lz_start_o stayed 0 for %0d cycles, expected a pulse", n);
        end
    endtask

    // Called in the KICK cycle; lz_done_i is raised in the len-th RUN cycle.
    task automatic run_line(input int len, input bit feed, input bit last,
                            input bit push_next, input bit next_lst, input int next_row, input int w);
        tick();
        chk("run_lst", 64'(lz_lst_o), 64'(last));
        tick(len - 1);
        lz_done_i  = 1'b1;
        flt_line_i = feed;
        if (last)           push_ev(1'b1, cyc + 1, 1'b0, 0, 0);
        else if (push_next) push_ev(1'b0, cyc + 2, next_lst, next_row, w);
        tick();
        lz_done_i  = 1'b0;
        flt_line_i = 1'b0;
    endtask

    task automatic frame(input int w, input int h, input int lbase, input bit feed);
        int mx;
        int len;
        mx = 0;
        start_frame(w, h, 1'b1);
        for (int i = 0; i < h; i++) begin
            len = lbase + 2 * i;
            if (len > mx) mx = len;
            wait_kick();
            run_line(len, feed, i == h - 1, 1'b1, i + 1 == h - 1, i + 1, w);
        end
        tick(2);
        chk("frame_busy_end", 64'(busy_o), 64'd0);
        chk("frame_cyc_max", 64'(cyc_max_o), 64'(mx));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_done"}, 64'(done_o), 64'd0);
        chk({tag, "_busy"}, 64'(busy_o), 64'd0);
        chk({tag, "_start"}, 64'(lz_start_o), 64'd0);
        chk({tag, "_lst"}, 64'(lz_lst_o), 64'd0);
        chk({tag, "_ovf"}, 64'(crd_ovf_o), 64'd0);
        chk({tag, "_w"}, 64'(lz_w_o), 64'd0);
        chk({tag, "_cnt_h"}, 64'(cnt_h_o), 64'd0);
        chk({tag, "_crd"}, 64'(crd_o), 64'd0);
        chk({tag, "_cyc_max"}, 64'(cyc_max_o), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        cfg_w_i    = '0;
        cfg_h_i    = '0;
        start_i    = 1'b0;
        flt_line_i = 1'b0;
        lz_done_i  = 1'b0;
        tick(2);
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        // Basic frame: two preloaded credits, one credit returned per finished line.
        pulse_flt();
        pulse_flt();
        chk("preload_crd", 64'(crd_o), 64'd2);
        frame(256, 4, 5, 1'b1);
        chk("basic_crd_end", 64'(crd_o), 64'd2);
        chk("basic_w", 64'(lz_w_o), 64'd256);

        // Inc and dec in the KICK cycle, then overflow with no KICK.
        start_frame(8, 1, 1'b1);
        tick();
        flt_line_i = 1'b1;
        tick();
        flt_line_i = 1'b0;
        chk("incdec_crd", 64'(crd_o), 64'd2);
        chk("incdec_ovf", 64'(crd_ovf_o), 64'd0);
        flt_line_i = 1'b1;
        tick();
        flt_line_i = 1'b0;
        chk("ovf_crd", 64'(crd_o), 64'd2);
        chk("ovf_set", 64'(crd_ovf_o), 64'd1);
        lz_done_i = 1'b1;
        push_ev(1'b1, cyc + 1, 1'b0, 0, 0);
        tick();
        lz_done_i = 1'b0;
        tick(2);
        chk("ovf_frame_cyc_max", 64'(cyc_max_o), 64'd2);
        chk("ovf_sticky", 64'(crd_ovf_o), 64'd1);

        // Zero-size frames; the first start also clears the overflow flag.
        start_frame(16, 0, 1'b0);
        chk("zero_h_ovf_clr", 64'(crd_ovf_o), 64'd0);
        tick(2);
        chk("zero_h_busy", 64'(busy_o), 64'd0);
        start_frame(0, 5, 1'b0);
        tick(2);
        chk("zero_w_busy", 64'(busy_o), 64'd0);
        chk("zero_crd", 64'(crd_o), 64'd2);

        // Drain credit to zero.
        frame(8, 2, 3, 1'b0);
        chk("drain_crd", 64'(crd_o), 64'd0);

        // Starvation: held in WAIT until a credit arrives 20 cycles later.
        start_frame(32, 1, 1'b0);
        tick(19);
        chk("starve_busy", 64'(busy_o), 64'd1);
        chk("starve_crd", 64'(crd_o), 64'd0);
        flt_line_i = 1'b1;
        push_ev(1'b0, cyc + 2, 1'b1, 0, 32);
        tick();
        flt_line_i = 1'b0;
        wait_kick();
        run_line(4, 1'b0, 1'b1, 1'b0, 1'b0, 0, 32);
        tick(2);
        chk("starve_cyc_max", 64'(cyc_max_o), 64'd4);

        // Stray start during RUN and stray lz_done during WAIT.
        pulse_flt();
        start_frame(64, 2, 1'b1);
        wait_kick();
        tick();
        cfg_w_i = SIZE_W_WD'(999);
        cfg_h_i = SIZE_H_WD'(1);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("stray_start_busy", 64'(busy_o), 64'd1);
        chk("stray_start_row", 64'(cnt_h_o), 64'd0);
        chk("stray_start_w", 64'(lz_w_o), 64'd64);
        lz_done_i = 1'b1;
        tick();
        lz_done_i = 1'b0;
        tick();
        lz_done_i = 1'b1;
        tick();
        lz_done_i = 1'b0;
        tick(2);
        chk("stray_done_row", 64'(cnt_h_o), 64'd1);
        chk("stray_done_busy", 64'(busy_o), 64'd1);
        flt_line_i = 1'b1;
        push_ev(1'b0, cyc + 2, 1'b1, 1, 64);
        tick();
        flt_line_i = 1'b0;
        wait_kick();
        run_line(3, 1'b0, 1'b1, 1'b0, 1'b0, 0, 64);
        tick(2);
        chk("stray_busy_end", 64'(busy_o), 64'd0);
        chk("stray_cyc_max", 64'(cyc_max_o), 64'd3);

        // Asynchronous reset in the RUN phase of line 2.
        pulse_flt();
        pulse_flt();
        start_frame(128, 4, 1'b1);
        for (int i = 0; i < 2; i++) begin
            wait_kick();
            run_line(6, 1'b1, 1'b0, 1'b1, 1'b0, i + 1, 128);
        end
        wait_kick();
        tick(3);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("async_rst");
        tick();
        rst = 1'b0;
        tick();

        // Fresh single-line frame after reset.
        pulse_flt();
        start_frame(40, 1, 1'b1);
        wait_kick();
        run_line(300, 1'b0, 1'b1, 1'b0, 1'b0, 0, 40);
        tick(2);
        chk("post_rst_cyc_max", 64'(cyc_max_o), 64'd300);
        chk("post_rst_busy", 64'(busy_o), 64'd0);

        tick(2);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
